// File: rtl/ks_adder_if.sv
// Operand/result handshake bundle for the pipelined Kogge-Stone adder.
// The slave side is the adder; the master side is the operand source and result consumer.
interface ks_adder_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control and a global stall.
// Carry-in rides in prefix position 0, so G at position i is the carry into bit i.
module ks_adder_pipe #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 2
) (
  input logic       clk,
  input logic       rst_n,
  ks_adder_if.slave bus
);
  localparam int unsigned L  = $clog2(WIDTH);
  // Payload: {a_msb, bb_msb, gb_msb, pb[W], P[W], G[W]}
  localparam int unsigned DW = 3 * WIDTH + 3;

  if (WIDTH < 2 || STAGES < 1 || STAGES > L + 1) begin : g_bad_cfg
    $error("ks_adder_pipe: illegal WIDTH=%0d / STAGES=%0d", WIDTH, STAGES);
  end

  // True when a pipeline register follows prefix level lvl.
  function automatic logic is_boundary(int unsigned lvl);
    logic hit;
    hit = 1'b0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      if ((k * (L + 1)) / STAGES == lvl + 1) hit = 1'b1;
    end
    return hit;
  endfunction

  logic [DW-1:0] lvl_o [L+1];
  logic [DW-1:0] lvl_q [L+1];
  logic [L:0]    vld_o;
  logic [L:0]    vld_q;
  logic          stall_c;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] out_sum_d, out_sum_q;
  logic             out_cout_d, out_cout_q;
  logic             out_ovf_d, out_ovf_q;

  assign stall_c      = out_valid_q & ~bus.out_ready;
  assign bus.in_ready = ~stall_c;

  for (genvar j = 0; j <= L; j++) begin : g_lvl
    if (j == 0) begin : g_pg
      logic [WIDTH-1:0] bb, gb, pb;
      always_comb begin
        bb = bus.in_sub ? ~bus.in_b : bus.in_b;
        gb = bus.in_a & bb;
        pb = bus.in_a ^ bb;
      end
      assign lvl_o[0] = {bus.in_a[WIDTH-1], bb[WIDTH-1], gb[WIDTH-1], pb,
                         {pb[WIDTH-2:0], 1'b0}, {gb[WIDTH-2:0], bus.in_cin}};
      assign vld_o[0] = bus.in_valid & ~stall_c;
    end else begin : g_prefix
      localparam int unsigned SPAN = 1 << (j - 1);
      logic [WIDTH-1:0] g_in, p_in, g_out, p_out;
      // Positions below SPAN have no partner and pass through.
      always_comb begin
        g_in  = lvl_q[j-1][WIDTH-1:0];
        p_in  = lvl_q[j-1][2*WIDTH-1:WIDTH];
        g_out = g_in;
        p_out = p_in;
        for (int unsigned i = SPAN; i < WIDTH; i++) begin
          g_out[i] = g_in[i] | (p_in[i] & g_in[i-SPAN]);
          p_out[i] = p_in[i] & p_in[i-SPAN];
        end
      end
      assign lvl_o[j] = {lvl_q[j-1][DW-1:2*WIDTH], p_out, g_out};
      assign vld_o[j] = vld_q[j-1];
    end

    if (j < L && is_boundary(j)) begin : g_reg
      logic          v_d, v_q;
      logic [DW-1:0] dat_d, dat_q;
      always_comb begin
        v_d   = stall_c ? v_q : vld_o[j];
        dat_d = (!stall_c && vld_o[j]) ? lvl_o[j] : dat_q;
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q   <= 1'b0;
          dat_q <= '0;
        end else begin
          v_q   <= v_d;
          dat_q <= dat_d;
        end
      end
      assign lvl_q[j] = dat_q;
      assign vld_q[j] = v_q;
    end else begin : g_wire
      assign lvl_q[j] = lvl_o[j];
      assign vld_q[j] = vld_o[j];
    end
  end

  logic [WIDTH-1:0] fin_g, fin_pb, sum_c;
  logic             gb_msb, bb_msb, a_msb, cout_c, ovf_c;
  logic             unused_p;

  assign unused_p = ^lvl_q[L][2*WIDTH-1:WIDTH];

  always_comb begin
    fin_g  = lvl_q[L][WIDTH-1:0];
    fin_pb = lvl_q[L][3*WIDTH-1:2*WIDTH];
    gb_msb = lvl_q[L][3*WIDTH];
    bb_msb = lvl_q[L][3*WIDTH+1];
    a_msb  = lvl_q[L][3*WIDTH+2];
    sum_c  = fin_pb ^ fin_g;
    cout_c = gb_msb | (fin_pb[WIDTH-1] & fin_g[WIDTH-1]);
    ovf_c  = (a_msb == bb_msb) && (sum_c[WIDTH-1] != a_msb);
  end

  // Output register: data loads only with a valid result, holds otherwise.
  always_comb begin
    out_valid_d = stall_c ? out_valid_q : vld_q[L];
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;
    if (!stall_c && vld_q[L]) begin
      out_sum_d  = sum_c;
      out_cout_d = cout_c;
      out_ovf_d  = ovf_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_ovf   = out_ovf_q;
endmodule
